dram_req_scheduler: RTL and testbench
=====================================

DRAM_REQ_SCHEDULER -- requirements
Module: dram_req_scheduler

Interface
REQ-001 Parameters SHALL be as follows, one per line: name, default, meaning.
- DEPTH, 4, request FIFO entries (power of 2, ≥2).
- ROW_W, 15, row address width.
- TIMEOUT, 200, max cycles waiting for cmd_done before abort.

REQ-002 Ports SHALL be as follows, one per line: name, direction, width, meaning.
- clk, in, 1, sole clock; all state updates on posedge.
- rst_n, in, 1, reset, asynchronous, active-low.
- req_valid, in, 1, request offered.
- req_ready, out, 1, FIFO can accept.
- req_bg, in, 2, target bank group.
- req_b, in, 2, target bank.
- req_row, in, ROW_W, target row.
- precharge_all, in, 1, close all rows (honoured only in IDLE).
- cmd_done, in, 1, single-cycle pulse: dram_cmd finished sequence.
- en, out, 1, single-cycle start pulse to dram_cmd.
- POLICY, out, dram_policy_t (dram_defs), HIT/MISS/EMPTY/NULL for issued command.
- different_bg, out, 1, issued bank group differs from previous issue.
- different_b, out, 1, issued bank differs from previous issue.
- busy, out, 1, high in ISSUE or WAIT.
- timeout_err, out, 1, sticky abort flag.
- issued_count, out, 16, commands issued since reset (wraps).

Function
REQ-003 Push SHALL occur when req_valid && req_ready; req_ready SHALL equal FIFO-not-full (registered count, no bypass when full).
REQ-004 FIFO SHALL be in-order; pointers SHALL wrap modulo DEPTH; simultaneous push and pop SHALL leave count unchanged.
REQ-005 Open-row table: 16 entries indexed {bg,b}, each valid bit + ROW_W row.
REQ-006 FSM states SHALL be IDLE, ISSUE, and WAIT.
- IDLE→ISSUE when the FIFO is non-empty and precharge_all is low.
- ISSUE→WAIT unconditionally.
- WAIT→IDLE on cmd_done or on timeout.
REQ-007 In IDLE with precharge_all high, all valid bits SHALL clear at that edge and no issue SHALL occur that cycle.
REQ-008 On IDLE→ISSUE the head SHALL be popped and outputs registered; during the ISSUE cycle the following SHALL hold.
- en=1.
- POLICY=EMPTY if the entry is invalid, HIT if the row matches, MISS otherwise.
- different_bg = (req_bg != last_bg) or no prior issue.
- different_b = (req_b != last_b) or no prior issue.
REQ-009 At the ISSUE edge the table entry SHALL become valid with req_row, last_bg/last_b SHALL update, and issued_count SHALL increment.
REQ-010 POLICY, different_bg, and different_b SHALL hold their values through WAIT; POLICY SHALL return to NULL on entry to IDLE.
REQ-011 Latency: a request accepted at edge N into an empty FIFO with the FSM in IDLE SHALL produce en high in the cycle following edge N+1.
REQ-012 cmd_done SHALL be ignored outside WAIT.
REQ-013 A WAIT cycle counter SHALL abort at TIMEOUT cycles: set timeout_err, invalidate that bank's entry, and go to IDLE; cmd_done on the same edge SHALL take priority (no error).
REQ-014 en SHALL never be high in two consecutive cycles; at most one command SHALL be outstanding.

Reset
REQ-015 While rst_n=0 the block SHALL be forced to its reset state: FSM=IDLE, FIFO empty, all table entries invalid, no prior issue.
REQ-016 Output reset values SHALL be as follows.
- req_ready=1.
- en=0, POLICY=NULL.
- different_bg=0, different_b=0.
- busy=0, timeout_err=0, issued_count=0.
REQ-017 Reset asserted mid-WAIT SHALL abandon the command with no en pulse after release until a new push.

Verification
REQ-018 The bench SHALL cover the following directed scenarios.
- First request bg=0 b=0 row=5 → en pulse, POLICY=EMPTY, different_bg=1, different_b=1.
- Same request again after cmd_done → POLICY=HIT, different_bg=0, different_b=0.
- bg=0 b=0 row=9 → POLICY=MISS; a following bg=1 b=0 row=9 → EMPTY, different_bg=1, different_b=0.
- Push 5 requests with cmd_done withheld (DEPTH=4) → req_ready=0 after 4 queued; order is preserved on drain; issued_count=5.
- Withhold cmd_done for 200 cycles → timeout_err=1, FSM returns to IDLE, the next request to the same bank issues EMPTY.
- precharge_all in IDLE after a HIT setup, then a same-row request → POLICY=EMPTY; rst_n pulsed mid-WAIT → all outputs at reset values.

Source files
------------

// File: rtl/dram_req_scheduler.sv
// rtl/dram_req_scheduler.sv - in-order DRAM request scheduler with open-row policy tracking
package dram_defs;
  typedef enum logic [1:0] {NULL = 2'd0, EMPTY = 2'd1, HIT = 2'd2, MISS = 2'd3} dram_policy_t;
endpackage

module dram_req_scheduler #(
  parameter int DEPTH   = 4,
  parameter int ROW_W   = 15,
  parameter int TIMEOUT = 200
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [1:0]              req_bg,
  input  logic [1:0]              req_b,
  input  logic [ROW_W-1:0]        req_row,
  input  logic                    precharge_all,
  input  logic                    cmd_done,
  output logic                    en,
  output dram_defs::dram_policy_t POLICY,
  output logic                    different_bg,
  output logic                    different_b,
  output logic                    busy,
  output logic                    timeout_err,
  output logic [15:0]             issued_count
);
  import dram_defs::*;

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int EW = 4 + ROW_W;
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);
  localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t state_q, state_d;

  logic [EW-1:0]    fifo_mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      count;
  logic             push, pop;
  logic [1:0]       head_bg, head_b;
  logic [ROW_W-1:0] head_row;
  logic [3:0]       head_idx, cur_idx;
  dram_policy_t     head_policy;

  logic [15:0]      tbl_valid;
  logic [ROW_W-1:0] tbl_row [16];
  logic [1:0]       cur_bg, cur_b, last_bg, last_b;
  logic [ROW_W-1:0] cur_row;
  logic             has_prior;
  logic [CW-1:0]    wait_cnt;
  logic             issue_done, abort, clear_all;

  assign req_ready = (count != FULL_CNT);
  assign push      = req_valid && req_ready;
  assign {head_bg, head_b, head_row} = fifo_mem[rd_ptr];
  assign head_idx  = {head_bg, head_b};
  assign cur_idx   = {cur_bg, cur_b};
  assign busy      = (state_q != S_IDLE);

  always_comb begin
    head_policy = EMPTY;
    if (tbl_valid[head_idx])
      head_policy = (tbl_row[head_idx] == head_row) ? HIT : MISS;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // precharge_all wins over issuing so the table clear never races a pop
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    issue_done = 1'b0;
    abort      = 1'b0;
    clear_all  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (precharge_all) begin
          clear_all = 1'b1;
        end else if (count != '0) begin
          pop     = 1'b1;
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issue_done = 1'b1;
        state_d    = S_WAIT;
      end
      S_WAIT: begin
        if (cmd_done) begin
          state_d = S_IDLE;
        end else if (wait_cnt == WAIT_LAST) begin
          abort   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= {req_bg, req_b, req_row};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (issue_done) tbl_row[cur_idx] <= cur_row;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tbl_valid <= '0;
    end else if (clear_all) begin
      tbl_valid <= '0;
    end else if (issue_done) begin
      tbl_valid[cur_idx] <= 1'b1;
    end else if (abort) begin
      tbl_valid[cur_idx] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en           <= 1'b0;
      POLICY       <= NULL;
      different_bg <= 1'b0;
      different_b  <= 1'b0;
      cur_bg       <= '0;
      cur_b        <= '0;
      cur_row      <= '0;
    end else begin
      en <= pop;
      if (pop) begin
        POLICY       <= head_policy;
        different_bg <= !has_prior || (head_bg != last_bg);
        different_b  <= !has_prior || (head_b != last_b);
        cur_bg       <= head_bg;
        cur_b        <= head_b;
        cur_row      <= head_row;
      end else if (state_d == S_IDLE) begin
        POLICY <= NULL;
      end
    end
  end

  // issue bookkeeping lands on the edge leaving ISSUE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_bg      <= '0;
      last_b       <= '0;
      has_prior    <= 1'b0;
      issued_count <= '0;
      timeout_err  <= 1'b0;
      wait_cnt     <= '0;
    end else begin
      if (issue_done) begin
        last_bg      <= cur_bg;
        last_b       <= cur_b;
        has_prior    <= 1'b1;
        issued_count <= issued_count + 16'd1;
      end
      if (abort) timeout_err <= 1'b1;
      if (state_q == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
      else                   wait_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_dram_req_scheduler.sv
// tb/tb_dram_req_scheduler.sv - scoreboard bench for dram_req_scheduler
module tb_dram_req_scheduler;
  import dram_defs::*;

  localparam int ROW_W = 15;

  logic             clk = 1'b0;
  logic             rst_n, req_valid, req_ready, precharge_all, cmd_done;
  logic [1:0]       req_bg, req_b;
  logic [ROW_W-1:0] req_row;
  logic             en, different_bg, different_b, busy, timeout_err;
  dram_policy_t     POLICY;
  logic [15:0]      issued_count;

  dram_req_scheduler #(.DEPTH(4), .ROW_W(ROW_W), .TIMEOUT(200)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_bg(req_bg), .req_b(req_b), .req_row(req_row), .precharge_all(precharge_all),
    .cmd_done(cmd_done), .en(en), .POLICY(POLICY), .different_bg(different_bg),
    .different_b(different_b), .busy(busy), .timeout_err(timeout_err),
    .issued_count(issued_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    dram_policy_t pol;
    logic         dbg;
    logic         db;
  } exp_t;

  exp_t             exp_q[$];
  int               n_chk = 0;
  int               n_fail = 0;
  logic             m_valid [16];
  logic [ROW_W-1:0] m_row [16];
  logic [1:0]       m_last_bg, m_last_b;
  logic             m_prior;
  logic [15:0]      m_issued;
  logic             hold = 1'b0;
  logic             drop = 1'b0;

  task automatic chk(input string name, input int act, input int exp_v);
    n_chk++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    m_prior  = 1'b0;
    m_last_bg = '0;
    m_last_b  = '0;
    m_issued = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
  endtask

  // expected outcome follows purely from issue order and the open-row rules
  task automatic model_push(input logic [1:0] bg, input logic [1:0] b, input logic [ROW_W-1:0] row);
    exp_t e;
    int   idx;
    idx   = int'({bg, b});
    e.pol = !m_valid[idx] ? EMPTY : ((m_row[idx] == row) ? HIT : MISS);
    e.dbg = !m_prior || (bg != m_last_bg);
    e.db  = !m_prior || (b != m_last_b);
    exp_q.push_back(e);
    m_valid[idx] = 1'b1;
    m_row[idx]   = row;
    m_last_bg    = bg;
    m_last_b     = b;
    m_prior      = 1'b1;
    m_issued     = m_issued + 16'd1;
  endtask

  task automatic push_req(input logic [1:0] bg, input logic [1:0] b, input logic [ROW_W-1:0] row);
    int waited;
    req_valid = 1'b1;
    req_bg    = bg;
    req_b     = b;
    req_row   = row;
    waited    = 0;
    while (!req_ready && waited < 1000) begin
      @(negedge clk);
      waited++;
    end
    if (!req_ready) chk("push_ready_bound", 0, 1);
    @(posedge clk);
    model_push(bg, b, row);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int cyc;
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while ((exp_q.size() != 0 || busy) && cyc < 1000);
    if (cyc >= 1000) chk("wait_idle_bound", 0, 1);
  endtask

  task automatic wait_en();
    int cyc;
    cyc = 0;
    while (!en && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    if (!en) chk("wait_en_bound", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, int'(req_ready), 1);
    chk({tag, "_en"}, int'(en), 0);
    chk({tag, "_policy"}, int'(POLICY), int'(NULL));
    chk({tag, "_diff_bg"}, int'(different_bg), 0);
    chk({tag, "_diff_b"}, int'(different_b), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_timeout_err"}, int'(timeout_err), 0);
    chk({tag, "_issued_count"}, int'(issued_count), 0);
  endtask

  // monitor: pops an expectation at every en pulse and checks held/idle policy otherwise
  exp_t cur;
  logic prev_en = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_en = 1'b0;
    end else begin
      if (en) begin
        chk("en_not_back_to_back", int'(prev_en), 0);
        chk("busy_during_issue", int'(busy), 1);
        if (exp_q.size() == 0) begin
          chk("en_without_request", 1, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("issue_policy", int'(POLICY), int'(cur.pol));
          chk("issue_diff_bg", int'(different_bg), int'(cur.dbg));
          chk("issue_diff_b", int'(different_b), int'(cur.db));
        end
      end else if (busy) begin
        chk("wait_policy_hold", int'(POLICY), int'(cur.pol));
        chk("wait_diff_bg_hold", int'(different_bg), int'(cur.dbg));
        chk("wait_diff_b_hold", int'(different_b), int'(cur.db));
      end else begin
        chk("idle_policy_null", int'(POLICY), int'(NULL));
      end
      prev_en = en;
    end
  end

  // responder: completes each command after a short random delay unless held or dropped
  initial begin
    cmd_done = 1'b0;
    forever begin
      @(negedge clk);
      if (en && rst_n && !drop) begin
        while (hold) @(negedge clk);
        repeat ($urandom_range(1, 4)) @(negedge clk);
        cmd_done = 1'b1;
        @(negedge clk);
        cmd_done = 1'b0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_bg = '0;
    req_b = '0;
    req_row = '0;
    precharge_all = 1'b0;
    model_reset();
    cur = '{pol: NULL, dbg: 1'b0, db: 1'b0};
    repeat (3) @(negedge clk);
    check_reset_outputs("in_reset");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("after_reset");

    // first request: latency and EMPTY with no prior issue
    push_req(2'd0, 2'd0, 15'd5);
    chk("latency_no_en_early", int'(en), 0);
    @(negedge clk);
    chk("latency_en", int'(en), 1);
    wait_idle();
    push_req(2'd0, 2'd0, 15'd5);
    wait_idle();
    push_req(2'd0, 2'd0, 15'd9);
    wait_idle();
    push_req(2'd1, 2'd0, 15'd9);
    wait_idle();
    chk("issued_after_directed", int'(issued_count), int'(m_issued));

    // backpressure with cmd_done held
    hold = 1'b1;
    for (int i = 0; i < 5; i++)
      push_req(2'($urandom_range(0, 1)), 2'($urandom_range(0, 1)), 15'($urandom_range(0, 2)));
    chk("full_req_ready", int'(req_ready), 0);
    hold = 1'b0;
    wait_idle();
    chk("req_ready_after_drain", int'(req_ready), 1);
    chk("issued_after_burst", int'(issued_count), int'(m_issued));

    // timeout on a bank with an open row
    push_req(2'd2, 2'd1, 15'd7);
    wait_idle();
    chk("no_timeout_yet", int'(timeout_err), 0);
    drop = 1'b1;
    push_req(2'd2, 2'd1, 15'd7);
    m_valid[int'({2'd2, 2'd1})] = 1'b0;
    wait_en();
    repeat (200) @(negedge clk);
    chk("timeout_still_busy", int'(busy), 1);
    chk("timeout_not_early", int'(timeout_err), 0);
    @(negedge clk);
    chk("timeout_back_idle", int'(busy), 0);
    chk("timeout_err_set", int'(timeout_err), 1);
    drop = 1'b0;
    push_req(2'd2, 2'd1, 15'd7);
    wait_idle();
    chk("timeout_err_sticky", int'(timeout_err), 1);

    // precharge_all after a HIT setup, with a request waiting behind it
    push_req(2'd3, 2'd3, 15'd11);
    push_req(2'd3, 2'd3, 15'd11);
    wait_idle();
    precharge_all = 1'b1;
    model_clear();
    push_req(2'd3, 2'd3, 15'd11);
    for (int i = 0; i < 3; i++) begin
      chk("precharge_blocks_issue", int'(en), 0);
      @(negedge clk);
    end
    precharge_all = 1'b0;
    wait_idle();
    chk("issued_after_precharge", int'(issued_count), int'(m_issued));

    // randomized traffic with occasional precharge
    for (int i = 0; i < 40; i++) begin
      push_req(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 15'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 3)) @(negedge clk);
      if (i % 10 == 9) begin
        wait_idle();
        chk("issued_random", int'(issued_count), int'(m_issued));
        if ($urandom_range(0, 1) == 1) begin
          precharge_all = 1'b1;
          model_clear();
          @(negedge clk);
          precharge_all = 1'b0;
        end
      end
    end
    wait_idle();

    // reset asserted mid-WAIT
    hold = 1'b1;
    push_req(2'd1, 2'd2, 15'd3);
    wait_en();
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("mid_wait_reset");
    exp_q.delete();
    model_reset();
    @(negedge clk);
    hold = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check_reset_outputs("after_mid_wait_reset");
    push_req(2'd0, 2'd0, 15'd5);
    wait_idle();
    chk("issued_after_reset", int'(issued_count), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
